topk_stream_sorter: RTL and testbench

Parametrised successor to the two-sub-heap sorter with overflow FIFOs. It keeps the best DEPTH entries of an unbounded input stream in a sorted register array that inserts in one cycle. On flush it drains them in sorted order over a valid/ready output. Sort direction is chosen by parameter (top-K largest or smallest), and both ports support backpressure, which the previous generation did not. It sits between the feature-score producer and the keypoint selection logic.

---
 rtl/topk_stream_sorter.sv | 131 +++++++++++++
 tb/tb_topk_stream_sorter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/topk_stream_sorter.sv
// Top-K stream sorter: keeps the best DEPTH entries of a stream in a sorted register
// array with single-cycle insertion, then drains them in order over valid/ready.
module topk_stream_sorter #(
  parameter int DATA_WIDTH = 16,
  parameter int KEY_WIDTH  = 4,
  parameter int DEPTH      = 8,
  parameter int MODE_MAX   = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         init,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_last,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [CNT_WIDTH-1:0]         drop_cnt
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [DATA_WIDTH-1:0] KEY_ONES  = DATA_WIDTH'((64'd1 << KEY_WIDTH) - 64'd1);
  localparam logic [DATA_WIDTH-1:0] MIN_EMPTY = {2'b01, {(DATA_WIDTH-2){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MAX_EMPTY = {2'b11, {(DATA_WIDTH-2){1'b0}}} | KEY_ONES;
  localparam logic [DATA_WIDTH-1:0] EMPTY     = (MODE_MAX != 0) ? MIN_EMPTY : MAX_EMPTY;

  typedef enum logic {FILL, DRAIN} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   slot     [DEPTH];
  logic [DATA_WIDTH-1:0]   ins_slot [DEPTH];
  logic [DEPTH-1:0]        worse;
  logic                    in_norm;
  logic                    accept;
  logic                    insert_ok;
  logic                    drop_evt;

  // MIN sentinel < normal < MAX sentinel; only normal entries order by key.
  function automatic logic [1:0] rank(input logic [DATA_WIDTH-1:0] v);
    case (v[DATA_WIDTH-1 -: 2])
      2'b01:   rank = 2'd0;
      2'b00:   rank = 2'd1;
      default: rank = 2'd2;
    endcase
  endfunction

  function automatic logic less(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    logic [1:0] ra;
    logic [1:0] rb;
    ra = rank(a);
    rb = rank(b);
    if (ra != rb) less = (ra < rb);
    else          less = (ra == 2'd1) && (a[KEY_WIDTH-1:0] < b[KEY_WIDTH-1:0]);
  endfunction

  always_comb begin
    in_norm = (in_data[DATA_WIDTH-1 -: 2] == 2'b00);
    worse   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      worse[i] = (MODE_MAX != 0) ? less(slot[i], in_data) : less(in_data, slot[i]);
    end
    // Array is sorted, so worse[] is a thermometer: the first set bit is the insert point.
    ins_slot[0] = worse[0] ? in_data : slot[0];
    for (int unsigned i = 1; i < DEPTH; i++) begin
      if (!worse[i])        ins_slot[i] = slot[i];
      else if (!worse[i-1]) ins_slot[i] = in_data;
      else                  ins_slot[i] = slot[i-1];
    end
    accept    = (state == FILL) && in_valid && in_ready;
    insert_ok = accept && in_norm && (worse != '0);
    drop_evt  = accept && (!in_norm || (worse == '0) || (count == CW'(DEPTH)));
  end

  assign busy      = (state == DRAIN);
  assign out_valid = busy && (count != '0);
  assign out_last  = out_valid && (count == CW'(1));
  assign out_data  = out_valid ? slot[0] : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= FILL;
      in_ready <= 1'b0;
      count    <= '0;
      drop_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) slot[i] <= EMPTY;
    end else if (init) begin
      state    <= FILL;
      in_ready <= 1'b1;
      count    <= '0;
      drop_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) slot[i] <= EMPTY;
    end else begin
      if (drop_evt && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
      case (state)
        FILL: begin
          if (insert_ok) begin
            for (int unsigned i = 0; i < DEPTH; i++) slot[i] <= ins_slot[i];
            if (count != CW'(DEPTH)) count <= count + CW'(1);
          end
          if (flush) begin
            state    <= DRAIN;
            in_ready <= 1'b0;
          end else begin
            in_ready <= 1'b1;
          end
        end
        DRAIN: begin
          if (count == '0) begin
            state    <= FILL;
            in_ready <= 1'b1;
          end else if (out_ready) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) slot[i] <= slot[i+1];
            slot[DEPTH-1] <= EMPTY;
            count         <= count - CW'(1);
            if (count == CW'(1)) begin
              state    <= FILL;
              in_ready <= 1'b1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_topk_stream_sorter.sv
// Bench for topk_stream_sorter: a max-mode and a min-mode instance share one stimulus
// stream and are compared against a stable-selection reference model.
module tb_topk_stream_sorter;

  logic        clk;
  logic        rstn;
  logic        init;
  logic        in_valid;
  logic [15:0] in_data;
  logic        flush;
  logic        out_ready;

  logic        dm_in_ready, dm_out_valid, dm_out_last, dm_busy;
  logic [15:0] dm_out_data, dm_drop;
  logic [3:0]  dm_count;
  logic        dn_in_ready, dn_out_valid, dn_out_last, dn_busy;
  logic [15:0] dn_out_data, dn_drop;
  logic [3:0]  dn_count;

  topk_stream_sorter #(.DATA_WIDTH(16), .KEY_WIDTH(4), .DEPTH(8), .MODE_MAX(1), .CNT_WIDTH(16)) dut_max (
    .clk(clk), .rstn(rstn), .init(init), .in_valid(in_valid), .in_ready(dm_in_ready),
    .in_data(in_data), .flush(flush), .out_valid(dm_out_valid), .out_ready(out_ready),
    .out_data(dm_out_data), .out_last(dm_out_last), .busy(dm_busy), .count(dm_count),
    .drop_cnt(dm_drop));

  topk_stream_sorter #(.DATA_WIDTH(16), .KEY_WIDTH(4), .DEPTH(8), .MODE_MAX(0), .CNT_WIDTH(16)) dut_min (
    .clk(clk), .rstn(rstn), .init(init), .in_valid(in_valid), .in_ready(dn_in_ready),
    .in_data(in_data), .flush(flush), .out_valid(dn_out_valid), .out_ready(out_ready),
    .out_data(dn_out_data), .out_last(dn_out_last), .busy(dn_busy), .count(dn_count),
    .drop_cnt(dn_drop));

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // Reference model: every accepted normal entry in arrival order, plus the drop tally.
  logic [15:0] hist [$];
  logic [15:0] emax [$];
  logic [15:0] emin [$];
  int          mdrop = 0;

  task automatic model_accept(input logic [15:0] d);
    if (d[15:14] != 2'b00) mdrop++;
    else begin
      if (hist.size() >= 8) mdrop++;
      hist.push_back(d);
    end
  endtask

  // Best-8 by repeated selection; strict compare keeps the earliest of equal keys.
  task automatic build_exp();
    logic [15:0] pool [$];
    int b;
    pool = hist; emax.delete();
    while (emax.size() < 8 && pool.size() > 0) begin
      b = 0;
      for (int j = 1; j < pool.size(); j++) if (pool[j][3:0] > pool[b][3:0]) b = j;
      emax.push_back(pool[b]); pool.delete(b);
    end
    pool = hist; emin.delete();
    while (emin.size() < 8 && pool.size() > 0) begin
      b = 0;
      for (int j = 1; j < pool.size(); j++) if (pool[j][3:0] < pool[b][3:0]) b = j;
      emin.push_back(pool[b]); pool.delete(b);
    end
  endtask

  function automatic logic [15:0] rand_entry();
    logic [15:0] d;
    int r;
    d = 16'($urandom);
    r = $urandom_range(0, 9);
    d[15:14] = (r == 0) ? 2'b01 : (r == 1) ? 2'b11 : (r == 2) ? 2'b10 : 2'b00;
    return d;
  endfunction

  task automatic push(input logic [15:0] d);
    in_valid = 1; in_data = d; model_accept(d);
    @(negedge clk);
    check("in_ready_fill", {30'd0, dm_in_ready, dn_in_ready}, 32'h3);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic push_chk(input logic [15:0] d);
    int mc;
    push(d);
    mc = (hist.size() > 8) ? 8 : hist.size();
    @(negedge clk);
    check("count_model", dm_count, mc);
    check("count_min_model", dn_count, mc);
    check("drop_model", dm_drop, mdrop);
    check("drop_min_model", dn_drop, mdrop);
    @(posedge clk); #1;
  endtask

  task automatic do_drain(input int rmode, input bit fl_in_drain, input bit with_ent, input logic [15:0] ent);
    int n, idx, cyc;
    if (with_ent) begin in_valid = 1; in_data = ent; model_accept(ent); end
    flush = 1;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    build_exp(); n = emax.size(); hist.delete();
    idx = 0; cyc = 0;
    while (idx < n && cyc < 200) begin
      out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((cyc % 3) == 0) : 1'($urandom_range(0, 1));
      flush = fl_in_drain && (cyc == 1);
      @(negedge clk);
      check("ov_max", dm_out_valid, 1);
      check("ov_min", dn_out_valid, 1);
      check("od_max", dm_out_data, emax[idx]);
      check("od_min", dn_out_data, emin[idx]);
      check("last_max", dm_out_last, idx == n - 1);
      check("last_min", dn_out_last, idx == n - 1);
      check("busy_drain", {30'd0, dm_busy, dn_busy}, 32'h3);
      check("in_ready_drain", {30'd0, dm_in_ready, dn_in_ready}, 32'h0);
      @(posedge clk); #1;
      if (out_ready) idx++;
      cyc++;
    end
    if (idx < n) check("drain_timeout", idx, n);
    out_ready = 0; flush = 0;
    if (n == 0) begin
      @(negedge clk);
      check("empty_busy", dm_busy, 1);
      check("empty_ov", dm_out_valid | dn_out_valid, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("post_busy", dm_busy | dn_busy, 0);
    check("post_ov", dm_out_valid | dn_out_valid, 0);
    check("post_count", {dm_count, dn_count}, 0);
    check("post_in_ready", {30'd0, dm_in_ready, dn_in_ready}, 32'h3);
    check("post_drop", dm_drop, mdrop);
    @(posedge clk); #1;
  endtask

  task automatic mid_abort(input bit use_rst);
    push(16'h4001); push(16'h0006); push(16'h000B); push(16'h0002); push(16'h0108);
    build_exp();
    flush = 1;
    @(posedge clk); #1;
    flush = 0; out_ready = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("abort_od_max", dm_out_data, emax[k]);
      check("abort_od_min", dn_out_data, emin[k]);
      @(posedge clk); #1;
    end
    out_ready = 0;
    if (!use_rst) begin
      init = 1;
      @(posedge clk); #1;
      init = 0;
      @(negedge clk);
      check("init_ov", dm_out_valid | dn_out_valid, 0);
      check("init_count", {dm_count, dn_count}, 0);
      check("init_drop", {dm_drop, dn_drop}, 0);
      check("init_busy", dm_busy | dn_busy, 0);
      check("init_in_ready", {30'd0, dm_in_ready, dn_in_ready}, 32'h3);
    end else begin
      #2 rstn = 0;
      #1;
      check("rst_ov", dm_out_valid | dn_out_valid, 0);
      check("rst_count", {dm_count, dn_count}, 0);
      check("rst_drop", {dm_drop, dn_drop}, 0);
      check("rst_busy", dm_busy | dn_busy, 0);
      check("rst_in_ready", dm_in_ready | dn_in_ready, 0);
      check("rst_od", {dm_out_data, dn_out_data}, 0);
      @(posedge clk); #1;
      rstn = 1;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_rel_in_ready", {30'd0, dm_in_ready, dn_in_ready}, 32'h3);
    end
    hist.delete(); mdrop = 0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    int          grp;
    logic [15:0] data;
    int          exp_cnt;
    int          exp_drop;
  } vec_t;
  vec_t tbl [$];

  task automatic add_vec(input int g, input logic [15:0] d, input int c, input int dr);
    vec_t v;
    v.grp = g; v.data = d; v.exp_cnt = c; v.exp_drop = dr;
    tbl.push_back(v);
  endtask

  task automatic run_group(input int g);
    foreach (tbl[i]) begin
      if (tbl[i].grp == g) begin
        push(tbl[i].data);
        @(negedge clk);
        check("tbl_count_max", dm_count, tbl[i].exp_cnt);
        check("tbl_count_min", dn_count, tbl[i].exp_cnt);
        check("tbl_drop_max", dm_drop, tbl[i].exp_drop);
        check("tbl_drop_min", dn_drop, tbl[i].exp_drop);
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int np;
    clk = 0; rstn = 0; init = 0; in_valid = 0; in_data = 0; flush = 0; out_ready = 0;

    add_vec(1, 16'h0003, 1, 0); add_vec(1, 16'h0009, 2, 0); add_vec(1, 16'h0001, 3, 0);
    add_vec(1, 16'h0109, 4, 0); add_vec(1, 16'h0005, 5, 0);
    add_vec(2, 16'h0107, 1, 0); add_vec(2, 16'h0202, 2, 0); add_vec(2, 16'h0307, 3, 0);
    add_vec(2, 16'h040F, 4, 0); add_vec(2, 16'hC00A, 4, 1); add_vec(2, 16'h8003, 4, 2);
    add_vec(2, 16'h4005, 4, 3);
    for (int i = 0; i < 12; i++) add_vec(3, 16'(i), (i < 8) ? i + 1 : 8, (i < 8) ? 0 : i - 7);

    #12;
    check("reset_in_ready", dm_in_ready | dn_in_ready, 0);
    check("reset_ov", dm_out_valid | dn_out_valid, 0);
    check("reset_last", dm_out_last | dn_out_last, 0);
    check("reset_busy", dm_busy | dn_busy, 0);
    check("reset_count", {dm_count, dn_count}, 0);
    check("reset_drop", {dm_drop, dn_drop}, 0);
    check("reset_od", {dm_out_data, dn_out_data}, 0);
    @(posedge clk); #1;
    rstn = 1;
    @(posedge clk); #1;

    run_group(1);
    do_drain(0, 0, 0, 16'h0);
    run_group(2);
    do_drain(0, 0, 0, 16'h0);
    init = 1;
    @(posedge clk); #1;
    init = 0; hist.delete(); mdrop = 0;
    run_group(3);
    do_drain(0, 0, 0, 16'h0);

    for (int i = 0; i < 10; i++) push_chk({2'b00, 10'(i), 4'($urandom_range(0, 15))});
    do_drain(1, 0, 0, 16'h0);
    push_chk(16'h0004); push_chk(16'h000C);
    do_drain(0, 0, 1, 16'h0208);
    do_drain(0, 0, 0, 16'h0);
    push_chk(16'h0001); push_chk(16'h000E); push_chk(16'h0007);
    do_drain(1, 1, 0, 16'h0);
    mid_abort(0);
    mid_abort(1);

    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 7) == 0) begin
        init = 1;
        @(posedge clk); #1;
        init = 0; hist.delete(); mdrop = 0;
      end
      np = $urandom_range(0, 14);
      for (int i = 0; i < np; i++) push_chk(rand_entry());
      do_drain(2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_entry());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
